mux_2to1: RTL and testbench

MUX_2TO1 -- requirements
Module: mux_2to1

---
 rtl/mux_pkg.sv | 8 +
 rtl/sat_counter.sv | 36 +++
 rtl/mux_2to1.sv | 56 +++++
 tb/tb_mux_2to1.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared defaults for the 2:1 mux slice: data width and select-change
// counter width used by mux_2to1 and sat_counter.
package mux_pkg;

    localparam int WIDTH_DEFAULT = 1;
    localparam int CNT_W_DEFAULT = 8;

endpackage : mux_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones, clears on a
// synchronous active-high reset.
module sat_counter
    import mux_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // NOTE: default assignment first so every path drives count_d; no latch.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/mux_2to1.sv
// 2:1 mux with a combinational output, a registered copy of the result and
// of the select, and a saturating count of sampled select transitions.
module mux_2to1
    import mux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_r,
    output logic             sel_q,
    output logic [CNT_W-1:0] sel_changes
);

    logic [WIDTH-1:0] out_r_d;
    logic [WIDTH-1:0] out_r_q;
    logic             sel_d;
    logic             sel_change;

    // Plain conditional operator keeps the usual X-merge behaviour on sel.
    assign out = sel ? b : a;

    always_comb begin
        out_r_d    = out;
        sel_d      = sel;
        sel_change = (sel != sel_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_r_q <= '0;
            sel_q   <= 1'b0;
        end else begin
            out_r_q <= out_r_d;
            sel_q   <= sel_d;
        end
    end

    assign out_r = out_r_q;

    // Reset inside the counter wins over a transition seen in the same cycle.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sel_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (sel_change),
        .count (sel_changes)
    );

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: three instances (default, 2-bit counter,
// 8-bit data) checked against a scoreboard of predicted registered outputs.
module tb_mux_2to1;

    typedef struct {
        logic [7:0] out_r;
        logic       sel_q;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       a0, b0, sel0, out0, out_r0, sel_q0;
    logic [7:0] cnt0;
    logic       a1, b1, sel1, out1, out_r1, sel_q1;
    logic [1:0] cnt1;
    logic [7:0] a2, b2, out2, out_r2;
    logic       sel2, sel_q2;
    logic [7:0] cnt2;

    int n_vec = 0;
    int n_err = 0;

    exp_t       sb[3][$];
    logic       m_selq[3];
    logic [7:0] m_cnt[3];
    logic [7:0] m_max[3];

    mux_2to1 u_dflt (
        .clk (clk), .reset (reset), .a (a0), .b (b0), .sel (sel0),
        .out (out0), .out_r (out_r0), .sel_q (sel_q0), .sel_changes (cnt0)
    );

    mux_2to1 #(.WIDTH (1), .CNT_W (2)) u_sat (
        .clk (clk), .reset (reset), .a (a1), .b (b1), .sel (sel1),
        .out (out1), .out_r (out_r1), .sel_q (sel_q1), .sel_changes (cnt1)
    );

    mux_2to1 #(.WIDTH (8), .CNT_W (8)) u_wide (
        .clk (clk), .reset (reset), .a (a2), .b (b2), .sel (sel2),
        .out (out2), .out_r (out_r2), .sel_q (sel_q2), .sel_changes (cnt2)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Predict each instance's registered outputs, push them, clock, then pop and compare.
    task automatic edge_cycle(input string tag);
        logic [7:0] av[3];
        logic [7:0] bv[3];
        logic       sv[3];
        logic [7:0] act_out_r[3];
        logic       act_selq[3];
        logic [7:0] act_cnt[3];
        exp_t       e;
        av[0] = {7'd0, a0}; bv[0] = {7'd0, b0}; sv[0] = sel0;
        av[1] = {7'd0, a1}; bv[1] = {7'd0, b1}; sv[1] = sel1;
        av[2] = a2;         bv[2] = b2;         sv[2] = sel2;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_selq[i] = 1'b0;
                m_cnt[i]  = 8'd0;
                e.out_r   = 8'd0;
            end else begin
                if ((sv[i] !== m_selq[i]) && (m_cnt[i] != m_max[i])) begin
                    m_cnt[i] = m_cnt[i] + 8'd1;
                end
                m_selq[i] = sv[i];
                e.out_r   = sv[i] ? bv[i] : av[i];
            end
            e.sel_q = m_selq[i];
            e.cnt   = m_cnt[i];
            sb[i].push_back(e);
        end
        @(posedge clk);
        #1;
        act_out_r[0] = {7'd0, out_r0}; act_selq[0] = sel_q0; act_cnt[0] = cnt0;
        act_out_r[1] = {7'd0, out_r1}; act_selq[1] = sel_q1; act_cnt[1] = {6'd0, cnt1};
        act_out_r[2] = out_r2;         act_selq[2] = sel_q2; act_cnt[2] = cnt2;
        for (int i = 0; i < 3; i++) begin
            e = sb[i].pop_front();
            check($sformatf("%s.out_r[%0d]", tag, i), act_out_r[i], e.out_r);
            check($sformatf("%s.sel_q[%0d]", tag, i), {7'd0, act_selq[i]}, {7'd0, e.sel_q});
            check($sformatf("%s.cnt[%0d]", tag, i), act_cnt[i], e.cnt);
        end
    endtask

    initial begin
        m_max[0] = 8'd255; m_max[1] = 8'd3; m_max[2] = 8'd255;
        for (int i = 0; i < 3; i++) begin
            m_selq[i] = 1'b0;
            m_cnt[i]  = 8'd0;
        end
        reset = 1'b1;
        a0 = 1'b0; b0 = 1'b1; sel0 = 1'b0;
        a1 = 1'b0; b1 = 1'b1; sel1 = 1'b0;
        a2 = 8'hA5; b2 = 8'h3C; sel2 = 1'b0;
        #1;
        check("rst.out0", {7'd0, out0}, 8'h00);
        check("rst.out2", out2, 8'hA5);
        edge_cycle("rst");

        // Reset held while sel toggles: out tracks sel, state stays cleared.
        for (int k = 0; k < 4; k++) begin
            sel0 = ~sel0;
            #1;
            check("hold_rst.out0", {7'd0, out0}, sel0 ? 8'h01 : 8'h00);
            edge_cycle("hold_rst");
        end
        check("hold_rst.cnt0", cnt0, 8'd0);
        check("hold_rst.out_r0", {7'd0, out_r0}, 8'h00);

        reset = 1'b0;
        edge_cycle("release");

        // Zero-latency out, one-edge latency out_r.
        check("basic.out_sel0", {7'd0, out0}, 8'h00);
        sel0 = 1'b1;
        #1;
        check("basic.out_sel1", {7'd0, out0}, 8'h01);
        check("basic.out_r_before", {7'd0, out_r0}, 8'h00);
        edge_cycle("basic");
        check("basic.out_r_after", {7'd0, out_r0}, 8'h01);

        // Ten toggles spaced two clocks apart from a fresh reset.
        reset = 1'b1;
        sel0  = 1'b0;
        edge_cycle("tog_rst");
        reset = 1'b0;
        edge_cycle("tog_start");
        for (int k = 0; k < 10; k++) begin
            sel0 = ~sel0;
            #1;
            check("tog.out0", {7'd0, out0}, sel0 ? 8'h01 : 8'h00);
            edge_cycle("tog_a");
            edge_cycle("tog_b");
        end
        check("tog.cnt10", cnt0, 8'd10);

        // A 0->1->0 glitch between edges is not a transition.
        sel0 = 1'b1;
        #1;
        check("glitch.out_hi", {7'd0, out0}, 8'h01);
        sel0 = 1'b0;
        #1;
        check("glitch.out_lo", {7'd0, out0}, 8'h00);
        edge_cycle("glitch");
        check("glitch.cnt", cnt0, 8'd10);

        // Reset beats a pending transition in the same cycle.
        sel0  = 1'b1;
        reset = 1'b1;
        edge_cycle("rst_override");
        check("rst_override.cnt", cnt0, 8'd0);
        check("rst_override.sel_q", {7'd0, sel_q0}, 8'h00);

        // First edge after release with sel=1 counts once.
        reset = 1'b0;
        edge_cycle("first_edge");
        check("first_edge.cnt", cnt0, 8'd1);

        // 2-bit counter saturates at 3.
        for (int k = 0; k < 6; k++) begin
            sel1 = ~sel1;
            edge_cycle("sat");
        end
        check("sat.cnt", {6'd0, cnt1}, 8'd3);

        // 8-bit data path.
        sel2 = 1'b0;
        #1;
        check("wide.out_a", out2, 8'hA5);
        sel2 = 1'b1;
        #1;
        check("wide.out_b", out2, 8'h3C);
        edge_cycle("wide");
        check("wide.out_r", out_r2, 8'h3C);

        // Data changes alone never move the counter.
        a0 = 1'b1; b0 = 1'b0; a2 = 8'h00; b2 = 8'hFF;
        edge_cycle("data_only");
        check("data_only.cnt0", cnt0, 8'd1);
        check("data_only.out_r2", out_r2, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mux_2to1
